// File: rtl/cpu_pkg.sv
// Shared CPU constants: address/data widths, memory-unit FSM state codes and
// the PC control codes used by the sequencer.
package cpu_pkg;

    localparam int AW = 8;
    localparam int DW = 8;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACCESS = 2'b01;
    localparam logic [1:0] RESP   = 2'b10;

    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_LOAD = 2'b10;

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous RAM, DEPTH x DW, write-enable and 1-cycle registered read.
module ram_sp #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we)
                mem[addr] <= din;
            else
                dout <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_mar_unit.sv
// Memory-side endpoint of the PC address path: MAR, req/ack access FSM and RAM.
// Optional MAR_AUTOINC_EN: MAR post-increments when an access completes.
module mem_mar_unit
    import cpu_pkg::*;
#(
    parameter int AW    = cpu_pkg::AW,
    parameter int DW    = cpu_pkg::DW,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_in,
    input  logic          mar_ld,
    input  logic          req,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          ack,
    output logic          busy,
    output logic [AW-1:0] mar_out
);

    logic [1:0]    state;
    logic [AW-1:0] mar;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] ram_dout;
    logic          ram_en;
    logic          ram_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mar     <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        mar     <= mar_ld ? addr_in : mar;
                        we_q    <= we;
                        wdata_q <= wdata;
                        state   <= ACCESS;
                    end else if (mar_ld) begin
                        mar <= addr_in;
                    end
                end
                ACCESS: state <= RESP;
                RESP: begin
                    state <= IDLE;
                    if (!we_q)
                        rdata_q <= ram_dout;
`ifdef MAR_AUTOINC_EN
                    mar <= mar + AW'(1);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A reset on the ACCESS edge must also suppress the pending RAM write.
    assign ram_en = (state == ACCESS);
    assign ram_we = we_q && !rst;

    ram_sp #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (mar),
        .din  (wdata_q),
        .dout (ram_dout)
    );

    // Read data is presented straight from the RAM register during RESP and held after.
    assign rdata   = (state == RESP && !we_q) ? ram_dout : rdata_q;
    assign ack     = (state == RESP);
    assign busy    = (state == ACCESS) || (state == RESP);
    assign mar_out = mar;

endmodule

// File: tb/tb_mem_mar_unit.sv
// Self-checking bench for mem_mar_unit against a transaction-level memory model.
module tb_mem_mar_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] addr_in;
    logic       mar_ld;
    logic       req;
    logic       we;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ack;
    logic       busy;
    logic [7:0] mar_out;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_m [256];
    logic [7:0] mar_exp;
    logic [7:0] rdata_exp;

    always #5 clk = ~clk;

    mem_mar_unit #(.AW(8), .DW(8), .DEPTH(256)) dut (
        .clk     (clk),
        .rst     (rst),
        .addr_in (addr_in),
        .mar_ld  (mar_ld),
        .req     (req),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .ack     (ack),
        .busy    (busy),
        .mar_out (mar_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full transaction starting just after an edge in IDLE; optionally pokes req/mar_ld while busy.
    task automatic access(input bit ld, input logic [7:0] a, input bit w,
                          input logic [7:0] d, input bit poke);
        mar_ld = ld; addr_in = a; req = 1'b1; we = w; wdata = d;
        @(posedge clk); #1;
        if (ld) mar_exp = a;
        req = 1'b0; mar_ld = 1'b0;
        we = 1'($urandom); wdata = 8'($urandom); addr_in = 8'($urandom);
        check("acc_busy", busy, 1);
        check("acc_ack0", ack, 0);
        check("acc_mar", mar_out, mar_exp);
        if (poke) begin
            req = 1'b1; mar_ld = 1'b1; addr_in = 8'h33; we = 1'b1;
        end
        @(posedge clk); #1;
        req = 1'b0; mar_ld = 1'b0;
        if (w) mem_m[mar_exp] = d;
        else   rdata_exp = mem_m[mar_exp];
        check("resp_ack", ack, 1);
        check("resp_busy", busy, 1);
        check("resp_mar", mar_out, mar_exp);
        check("resp_rdata", rdata, rdata_exp);
        @(posedge clk); #1;
`ifdef MAR_AUTOINC_EN
        mar_exp = mar_exp + 8'd1;
`endif
        check("done_ack", ack, 0);
        check("done_busy", busy, 0);
        check("done_mar", mar_out, mar_exp);
        check("done_rdata", rdata, rdata_exp);
    endtask

    task automatic idle_cycle(input bit ld, input logic [7:0] a);
        mar_ld = ld; addr_in = a; req = 1'b0;
        we = 1'($urandom); wdata = 8'($urandom);
        @(posedge clk); #1;
        mar_ld = 1'b0;
        if (ld) mar_exp = a;
        check("idle_mar", mar_out, mar_exp);
        check("idle_ack", ack, 0);
        check("idle_busy", busy, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        mar_exp = 8'h00; rdata_exp = 8'h00;
    endtask

    initial begin
        rst = 1'b1; addr_in = '0; mar_ld = 1'b0; req = 1'b0; we = 1'b0; wdata = '0;
        do_reset();
        check("rst_mar", mar_out, 8'h00);
        check("rst_ack", ack, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 8'h00);

        // Fill the whole RAM so every later read has a known expectation.
        for (int i = 0; i < 256; i++)
            access(1'b1, 8'(i), 1'b1, 8'($urandom), 1'b0);

        // Write then read, including busy-time req/mar_ld rejection.
        access(1'b1, 8'h10, 1'b1, 8'hA5, 1'b1);
        access(1'b1, 8'h10, 1'b0, 8'h00, 1'b1);
        check("wr_rd_10", rdata, 8'hA5);

        // Wrap boundary.
        access(1'b1, 8'hFF, 1'b1, 8'h5A, 1'b0);
        access(1'b1, 8'h00, 1'b1, 8'hC3, 1'b0);
        access(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0);
        check("wrap_ff", rdata, 8'h5A);
        access(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        check("wrap_00", rdata, 8'hC3);

        // Reset in the acceptance cycle: nothing accepted, no ack.
        mar_ld = 1'b1; addr_in = 8'h20; req = 1'b1; we = 1'b1; wdata = 8'h77; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0; mar_ld = 1'b0;
        mar_exp = 8'h00; rdata_exp = 8'h00;
        for (int i = 0; i < 3; i++) begin
            check("rstacc_ack", ack, 0);
            check("rstacc_busy", busy, 0);
            @(posedge clk); #1;
        end
        check("rstacc_rdata", rdata, 8'h00);
        access(1'b1, 8'h20, 1'b0, 8'h00, 1'b0);

        // Reset on the ACCESS edge drops the pending write.
        mar_ld = 1'b1; addr_in = 8'h21; req = 1'b1; we = 1'b1; wdata = ~mem_m[8'h21];
        @(posedge clk); #1;
        req = 1'b0; mar_ld = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mar_exp = 8'h00; rdata_exp = 8'h00;
        check("rstmid_ack", ack, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_mar", mar_out, 8'h00);
        access(1'b1, 8'h21, 1'b0, 8'h00, 1'b0);

        // Sequential reads without mar_ld.
        access(1'b1, 8'h40, 1'b0, 8'h00, 1'b0);
        access(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        access(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
`ifdef MAR_AUTOINC_EN
        check("seq_rdata", rdata, mem_m[8'h42]);
        check("seq_mar", mar_out, 8'h43);
`else
        check("seq_rdata", rdata, mem_m[8'h40]);
        check("seq_mar", mar_out, 8'h40);
`endif

        // Randomised mix of accesses and idle cycles.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0)
                idle_cycle(1'($urandom), 8'($urandom));
            else
                access(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                       ($urandom_range(0, 4) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
